dp_ram_bytewr: RTL

Parametrised simple-dual-port RAM with byte write enables and configurable read behaviour. Port A is write-only with per-byte strobes and port B is read-only with a pipelined valid strobe. It is the generic on-chip store for instruction and data memories in the core: word-aligned CPU fetches on B, loader or store-unit writes on A. Compared with the fixed 32-bit/4K-word instruction memory it adds parametric width and depth, 1- or 2-cycle read latency, selectable read-during-write mode, and misalignment reporting.

---
 rtl/dp_ram_bytewr.sv | 129 ++++++++++++
 1 files changed

// File: rtl/dp_ram_bytewr.sv
// Simple-dual-port RAM: port A byte-strobed writes, port B pipelined reads
// with selectable latency, read-during-write mode and sticky misalignment flag.
module dp_ram_bytewr #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 4096,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WRITE_FIRST  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_en,
  input  logic [DATA_WIDTH/8-1:0] a_we,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  input  logic                    b_en,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic                    b_valid,
  input  logic                    err_clr,
  output logic                    misalign_err
);

  localparam int unsigned NB   = DATA_WIDTH / 8;
  localparam int unsigned LOWW = $clog2(NB);
  localparam int unsigned WW   = ADDR_WIDTH - LOWW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [WW-1:0]         a_word;
  logic [WW-1:0]         b_word;
  logic [DATA_WIDTH-1:0] rd_word;

  assign a_word = a_addr[ADDR_WIDTH-1:LOWW];
  assign b_word = b_addr[ADDR_WIDTH-1:LOWW];

  // Storage is deliberately not reset; writes are still blocked while in reset.
  always_ff @(posedge clk) begin
    if (rst_n && a_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (a_we[i]) mem[a_word][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[b_word];
    if (WRITE_FIRST != 0 && a_en && a_word == b_word) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (a_we[i]) rd_word[8*i +: 8] = a_wdata[8*i +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_valid_q, s1_valid_d;

  always_comb begin
    s1_valid_d = b_en;
    s1_data_d  = b_en ? rd_word : s1_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
      logic                  out_valid_q, out_valid_d;

      always_comb begin
        out_valid_d = s1_valid_q;
        out_data_d  = s1_valid_q ? s1_data_q : out_data_q;
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
        end else begin
          out_valid_q <= out_valid_d;
          out_data_q  <= out_data_d;
        end
      end

      assign b_rdata = out_data_q;
      assign b_valid = out_valid_q;
    end else begin : g_lat1
      assign b_rdata = s1_data_q;
      assign b_valid = s1_valid_q;
    end
  endgenerate

  logic a_mis, b_mis;

  generate
    if (LOWW > 0) begin : g_mis
      assign a_mis = a_en && (|a_we) && (|a_addr[LOWW-1:0]);
      assign b_mis = b_en && (|b_addr[LOWW-1:0]);
    end else begin : g_nomis
      assign a_mis = 1'b0;
      assign b_mis = 1'b0;
    end
  endgenerate

  logic err_q, err_d;

  // A new misaligned access beats a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (a_mis || b_mis) err_d = 1'b1;
    else if (err_clr)   err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign misalign_err = err_q;

endmodule
